// File: rtl/lab3_cache_dma_arb_pkg.sv
// Shared types for the two-cache DMA arbiter: FSM state, memory message
// type codes and the 64B line request/response message layouts.
package lab3_cache_dma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [5:0]   len;
        logic [511:0] data;
    } mem_req_64B_t;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [5:0]   len;
        logic [511:0] data;
    } mem_resp_64B_t;

    function automatic logic is_write(input logic [2:0] type_code);
        return type_code == MEM_TYPE_WRITE;
    endfunction

endpackage

// File: rtl/lab3_cache_rr_arb2.sv
// Combinational 2-way round-robin pick. prio names the favoured requester;
// the other one wins only when the favoured one is not asking.
module lab3_cache_rr_arb2 (
    input  logic [1:0] val,
    input  logic       prio,
    output logic [1:0] grant
);

    // One-hot grant: favoured requester first, otherwise the other one.
    always_comb begin
        grant    = 2'b00;
        grant[0] = val[0] & (~prio | ~val[1]);
        grant[1] = val[1] & ( prio | ~val[0]);
    end

endmodule

// File: rtl/lab3_cache_dma_arbiter.sv
// Shares one 64B-line DMA port between two caches. One transaction at a
// time: accept a request in IDLE, present it to the DMA in SEND, route the
// DMA response back to the owning cache in WAIT.
//
// state | meaning
// IDLE  | no transaction; round-robin pick among requesting caches
// SEND  | latched request presented to DMA until dma_req_rdy
// WAIT  | DMA response passed through to the granted cache
module lab3_cache_dma_arbiter
    import lab3_cache_dma_arb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,

    input  mem_req_64B_t  c0_req_msg,
    input  logic          c0_req_val,
    output logic          c0_req_rdy,
    output mem_resp_64B_t c0_resp_msg,
    output logic          c0_resp_val,
    input  logic          c0_resp_rdy,

    input  mem_req_64B_t  c1_req_msg,
    input  logic          c1_req_val,
    output logic          c1_req_rdy,
    output mem_resp_64B_t c1_resp_msg,
    output logic          c1_resp_val,
    input  logic          c1_resp_rdy,

    output mem_req_64B_t  dma_req_msg,
    output logic          dma_req_val,
    input  logic          dma_req_rdy,
    input  mem_resp_64B_t dma_resp_msg,
    input  logic          dma_resp_val,
    output logic          dma_resp_rdy,

    output logic          busy,
    output logic          grant_id
);

    state_t       state;
    state_t       state_next;
    logic         prio;
    mem_req_64B_t req_reg;
    logic [1:0]   grant;
    logic         accept;
    logic         sel_resp_rdy;
    logic         done;

    lab3_cache_rr_arb2 u_rr_arb (
        .val   ({c1_req_val, c0_req_val}),
        .prio  (prio),
        .grant (grant)
    );

    // Handshake and completion qualifiers shared by the FSM and datapath.
    always_comb begin
        accept       = (state == IDLE) && (grant != 2'b00) && !reset;
        sel_resp_rdy = grant_id ? c1_resp_rdy : c0_resp_rdy;
        // The DMA drops a write response after one cycle, so a write
        // completes whether or not the cache is ready to take it.
        done         = (state == WAIT) && dma_resp_val &&
                       (sel_resp_rdy || is_write(dma_resp_msg.type_));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = SEND;
            SEND:    if (dma_req_rdy) state_next = WAIT;
            WAIT:    if (done)        state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Request capture, owner tracking and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_reg  <= '0;
            grant_id <= 1'b0;
            prio     <= 1'b0;
        end else begin
            if (accept) begin
                req_reg  <= grant[1] ? c1_req_msg : c0_req_msg;
                grant_id <= grant[1];
            end
            if (done) begin
                prio <= ~grant_id;
            end
        end
    end

    // FSM outputs: request ready in IDLE, DMA request in SEND, routing in WAIT.
    always_comb begin
        c0_req_rdy   = 1'b0;
        c1_req_rdy   = 1'b0;
        c0_resp_msg  = '0;
        c0_resp_val  = 1'b0;
        c1_resp_msg  = '0;
        c1_resp_val  = 1'b0;
        dma_req_msg  = req_reg;
        dma_req_val  = 1'b0;
        dma_resp_rdy = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                c0_req_rdy = grant[0] && !reset;
                c1_req_rdy = grant[1] && !reset;
            end
            SEND: begin
                busy        = 1'b1;
                dma_req_val = 1'b1;
            end
            WAIT: begin
                busy         = 1'b1;
                dma_resp_rdy = sel_resp_rdy;
                if (grant_id) begin
                    c1_resp_msg = dma_resp_msg;
                    c1_resp_val = dma_resp_val;
                end else begin
                    c0_resp_msg = dma_resp_msg;
                    c0_resp_val = dma_resp_val;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lab3_cache_dma_arbiter.sv
// Scoreboard bench for the two-cache DMA arbiter: directed stimulus pushes
// expected grants, DMA requests and cache responses; a negedge monitor pops
// and compares whenever the DUT completes a handshake.
module tb_lab3_cache_dma_arbiter;
    import lab3_cache_dma_arb_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    mem_req_64B_t  c0_req_msg, c1_req_msg, dma_req_msg;
    logic          c0_req_val, c0_req_rdy, c1_req_val, c1_req_rdy;
    mem_resp_64B_t c0_resp_msg, c1_resp_msg, dma_resp_msg;
    logic          c0_resp_val, c0_resp_rdy, c1_resp_val, c1_resp_rdy;
    logic          dma_req_val, dma_req_rdy, dma_resp_val, dma_resp_rdy;
    logic          busy, grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    mem_req_64B_t  q_dma[$];
    mem_resp_64B_t q_r0[$];
    mem_resp_64B_t q_r1[$];
    int            q_grant[$];

    always #5 clk = ~clk;

    lab3_cache_dma_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .c0_req_msg   (c0_req_msg),
        .c0_req_val   (c0_req_val),
        .c0_req_rdy   (c0_req_rdy),
        .c0_resp_msg  (c0_resp_msg),
        .c0_resp_val  (c0_resp_val),
        .c0_resp_rdy  (c0_resp_rdy),
        .c1_req_msg   (c1_req_msg),
        .c1_req_val   (c1_req_val),
        .c1_req_rdy   (c1_req_rdy),
        .c1_resp_msg  (c1_resp_msg),
        .c1_resp_val  (c1_resp_val),
        .c1_resp_rdy  (c1_resp_rdy),
        .dma_req_msg  (dma_req_msg),
        .dma_req_val  (dma_req_val),
        .dma_req_rdy  (dma_req_rdy),
        .dma_resp_msg (dma_resp_msg),
        .dma_resp_val (dma_resp_val),
        .dma_resp_rdy (dma_resp_rdy),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    task automatic check(input string name, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic mem_req_64B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                            input logic [31:0] addr, input logic [31:0] word);
        mem_req_64B_t m;
        m.type_  = t;
        m.opaque = op;
        m.addr   = addr;
        m.len    = 6'd0;
        m.data   = {16{word}};
        return m;
    endfunction

    function automatic mem_resp_64B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                              input logic [31:0] word);
        mem_resp_64B_t m;
        m.type_  = t;
        m.opaque = op;
        m.test   = 2'd0;
        m.len    = 6'd0;
        m.data   = {16{word}};
        return m;
    endfunction

    // Monitor: compare every completed handshake against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (c0_req_val && c0_req_rdy) begin
                if (q_grant.size() == 0) check("grant_unexpected_c0", 1, 0);
                else check("grant_order", 0, q_grant.pop_front());
            end
            if (c1_req_val && c1_req_rdy) begin
                if (q_grant.size() == 0) check("grant_unexpected_c1", 1, 0);
                else check("grant_order", 1, q_grant.pop_front());
            end
            if (dma_req_val && dma_req_rdy) begin
                if (q_dma.size() == 0) check("dma_req_unexpected", 1, 0);
                else check("dma_req_msg", dma_req_msg, q_dma.pop_front());
            end
            if (c0_resp_val && c0_resp_rdy) begin
                if (q_r0.size() == 0) check("c0_resp_unexpected", 1, 0);
                else check("c0_resp_msg", c0_resp_msg, q_r0.pop_front());
            end
            if (c1_resp_val && c1_resp_rdy) begin
                if (q_r1.size() == 0) check("c1_resp_unexpected", 1, 0);
                else check("c1_resp_msg", c1_resp_msg, q_r1.pop_front());
            end
            if (c0_resp_val || c1_resp_val)
                check("resp_exclusive", c0_resp_val & c1_resp_val, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a requester's val and hold it until the handshake edge.
    task automatic req(input int id, input mem_req_64B_t m);
        bit ok = 0;
        if (id == 0) begin c0_req_msg = m; c0_req_val = 1'b1; end
        else         begin c1_req_msg = m; c1_req_val = 1'b1; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0) ? c0_req_rdy : c1_req_rdy) begin ok = 1; break; end
        end
        if (!ok) check("req_rdy_timeout", 0, 1);
        step();
        if (id == 0) c0_req_val = 1'b0;
        else         c1_req_val = 1'b0;
    endtask

    // Accept the pending DMA request, then present one response until taken.
    task automatic serve(input mem_resp_64B_t r);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dma_req_val && dma_req_rdy) begin ok = 1; break; end
        end
        if (!ok) check("dma_req_timeout", 0, 1);
        step();
        dma_resp_msg = r;
        dma_resp_val = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dma_resp_rdy || r.type_ == MEM_TYPE_WRITE) begin ok = 1; break; end
        end
        if (!ok) check("dma_resp_timeout", 0, 1);
        step();
        dma_resp_val = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_req_64B_t  ma, mb, mc, md, m1, m3, m4, m5, m5b, m6, m7;
        mem_resp_64B_t ra, rb, rc, rd, r1, r3, r4, r5, r5b, r6, r7;

        reset = 1'b1;
        c0_req_msg = '0; c1_req_msg = '0; dma_resp_msg = '0;
        c0_req_val = 1'b1; c1_req_val = 1'b0;
        c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
        dma_req_rdy = 1'b1; dma_resp_val = 1'b1;

        // Reset state: nothing asserted even with inputs active.
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_c0_req_rdy", c0_req_rdy, 0);
        check("rst_dma_req_val", dma_req_val, 0);
        check("rst_dma_resp_rdy", dma_resp_rdy, 0);
        check("rst_c0_resp_val", c0_resp_val, 0);
        step();
        c0_req_val = 1'b0; dma_resp_val = 1'b0;
        reset = 1'b0;
        step();

        // Simultaneous requests alternate strictly, starting with c0.
        ma = mk_req(MEM_TYPE_READ, 8'h11, 32'h0000_2000, 32'h0);
        mb = mk_req(MEM_TYPE_READ, 8'h22, 32'h0000_3000, 32'h0);
        mc = mk_req(MEM_TYPE_READ, 8'h33, 32'h0000_4000, 32'h0);
        md = mk_req(MEM_TYPE_READ, 8'h44, 32'h0000_5000, 32'h0);
        ra = mk_resp(MEM_TYPE_READ, 8'h11, 32'hAAAA_0001);
        rb = mk_resp(MEM_TYPE_READ, 8'h22, 32'hBBBB_0002);
        rc = mk_resp(MEM_TYPE_READ, 8'h33, 32'hCCCC_0003);
        rd = mk_resp(MEM_TYPE_READ, 8'h44, 32'hDDDD_0004);
        q_grant.push_back(0); q_grant.push_back(1);
        q_grant.push_back(0); q_grant.push_back(1);
        q_dma.push_back(ma); q_dma.push_back(mb); q_dma.push_back(mc); q_dma.push_back(md);
        q_r0.push_back(ra); q_r1.push_back(rb); q_r0.push_back(rc); q_r1.push_back(rd);
        c0_req_msg = ma; c1_req_msg = mb; c0_req_val = 1'b1; c1_req_val = 1'b1;
        @(negedge clk);
        check("pair1_c0_rdy", c0_req_rdy, 1);
        check("pair1_c1_rdy", c1_req_rdy, 0);
        step();
        c0_req_val = 1'b0;
        serve(ra);
        req(1, mb);
        serve(rb);
        c0_req_msg = mc; c1_req_msg = md; c0_req_val = 1'b1; c1_req_val = 1'b1;
        @(negedge clk);
        check("pair2_c0_rdy", c0_req_rdy, 1);
        check("pair2_c1_rdy", c1_req_rdy, 0);
        step();
        c0_req_val = 1'b0;
        serve(rc);
        req(1, md);
        serve(rd);

        // Single read from c0 at 0x1000; response routed only to c0.
        m1 = mk_req(MEM_TYPE_READ, 8'h5A, 32'h0000_1000, 32'h0);
        r1 = mk_resp(MEM_TYPE_READ, 8'h5A, 32'hA5A5_A5A5);
        q_grant.push_back(0); q_dma.push_back(m1); q_r0.push_back(r1);
        req(0, m1);
        @(negedge clk);
        check("t1_dma_req_val", dma_req_val, 1);
        check("t1_dma_addr", dma_req_msg.addr, 32'h0000_1000);
        check("t1_dma_opaque", dma_req_msg.opaque, 8'h5A);
        check("t1_grant_id", grant_id, 0);
        step();
        dma_resp_msg = r1; dma_resp_val = 1'b1;
        @(negedge clk);
        check("t1_c1_resp_val", c1_resp_val, 0);
        check("t1_c0_resp_val", c0_resp_val, 1);
        step();
        dma_resp_val = 1'b0;
        @(negedge clk);
        check("t1_busy_after", busy, 0);

        // Write from c1 completes with c1_resp_rdy low.
        m3 = mk_req(MEM_TYPE_WRITE, 8'h77, 32'h0000_8040, 32'hDEAD_BEEF);
        r3 = mk_resp(MEM_TYPE_WRITE, 8'h77, 32'h0);
        c1_resp_rdy = 1'b0;
        q_grant.push_back(1); q_dma.push_back(m3);
        step();
        req(1, m3);
        @(negedge clk);
        step();
        dma_resp_msg = r3; dma_resp_val = 1'b1;
        @(negedge clk);
        check("t3_c1_resp_val", c1_resp_val, 1);
        check("t3_dma_resp_rdy", dma_resp_rdy, 0);
        check("t3_c1_resp_type", c1_resp_msg.type_, MEM_TYPE_WRITE);
        step();
        dma_resp_val = 1'b0;
        @(negedge clk);
        check("t3_busy_after", busy, 0);
        c1_resp_rdy = 1'b1;

        // Read with c0_resp_rdy low for 5 cycles.
        m4 = mk_req(MEM_TYPE_READ, 8'h04, 32'h0000_9000, 32'h0);
        r4 = mk_resp(MEM_TYPE_READ, 8'h04, 32'h1234_5678);
        q_grant.push_back(0); q_dma.push_back(m4);
        step();
        req(0, m4);
        @(negedge clk);
        step();
        c0_resp_rdy = 1'b0;
        dma_resp_msg = r4; dma_resp_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_dma_resp_rdy_low", dma_resp_rdy, 0);
            check("t4_busy_wait", busy, 1);
            step();
        end
        c0_resp_rdy = 1'b1;
        q_r0.push_back(r4);
        @(negedge clk);
        check("t4_dma_resp_rdy_high", dma_resp_rdy, 1);
        step();
        dma_resp_val = 1'b0;
        @(negedge clk);
        check("t4_busy_after", busy, 0);

        // DMA stalls the request for 4 cycles; c1 waits for completion.
        m5  = mk_req(MEM_TYPE_READ, 8'h55, 32'h0000_A000, 32'h0);
        m5b = mk_req(MEM_TYPE_READ, 8'h5B, 32'h0000_B000, 32'h0);
        r5  = mk_resp(MEM_TYPE_READ, 8'h55, 32'h5555_5555);
        r5b = mk_resp(MEM_TYPE_READ, 8'h5B, 32'h5B5B_5B5B);
        q_grant.push_back(0); q_dma.push_back(m5); q_r0.push_back(r5);
        q_grant.push_back(1); q_dma.push_back(m5b); q_r1.push_back(r5b);
        step();
        dma_req_rdy = 1'b0;
        req(0, m5);
        c1_req_msg = m5b; c1_req_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_dma_req_val", dma_req_val, 1);
            check("t5_dma_req_stable", dma_req_msg, m5);
            check("t5_c1_req_rdy", c1_req_rdy, 0);
            step();
        end
        dma_req_rdy = 1'b1;
        serve(r5);
        req(1, m5b);
        serve(r5b);

        // Reset mid-WAIT abandons the transaction asynchronously.
        m6 = mk_req(MEM_TYPE_READ, 8'h66, 32'h0000_C000, 32'h0);
        r6 = mk_resp(MEM_TYPE_READ, 8'h66, 32'h6666_6666);
        q_grant.push_back(0); q_dma.push_back(m6);
        req(0, m6);
        @(negedge clk);
        step();
        c0_resp_rdy = 1'b0;
        dma_resp_msg = r6; dma_resp_val = 1'b1;
        @(negedge clk);
        check("t6_busy_before", busy, 1);
        check("t6_c0_resp_val_before", c0_resp_val, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy_rst", busy, 0);
        check("t6_dma_req_val_rst", dma_req_val, 0);
        check("t6_dma_resp_rdy_rst", dma_resp_rdy, 0);
        check("t6_c0_resp_val_rst", c0_resp_val, 0);
        check("t6_c1_resp_val_rst", c1_resp_val, 0);
        step();
        dma_resp_val = 1'b0; c0_resp_rdy = 1'b1;
        step();
        reset = 1'b0;
        m7 = mk_req(MEM_TYPE_READ, 8'h07, 32'h0000_D000, 32'h0);
        r7 = mk_resp(MEM_TYPE_READ, 8'h07, 32'h7777_7777);
        q_grant.push_back(1); q_dma.push_back(m7); q_r1.push_back(r7);
        step();
        req(1, m7);
        serve(r7);

        repeat (2) @(negedge clk);
        check("sb_drain_grant", q_grant.size(), 0);
        check("sb_drain_dma", q_dma.size(), 0);
        check("sb_drain_r0", q_r0.size(), 0);
        check("sb_drain_r1", q_r1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lab3_cache_dma_arbiter.md
# lab3_cache_dma_arbiter

Two-requester arbiter that shares a single 64B cache-line memory port (the cache-to-memory DMA engine) between two caches, e.g. instruction cache (requester 0) and data cache (requester 1). Grants one line transaction at a time in round-robin order, holds the grant until the DMA returns the matching response, and routes that response back to the granted cache. Sits between the two cache memory ports and the DMA's cache-side port.

## Interface
Parameters:
- none; requester count fixed at 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- c0_req_msg  in  mem_req_64B_t  requester 0 line request
- c0_req_val / c0_req_rdy  in / out  1  requester 0 request handshake
- c0_resp_msg  out  mem_resp_64B_t  response to requester 0
- c0_resp_val / c0_resp_rdy  out / in  1  requester 0 response handshake
- c1_req_msg, c1_req_val, c1_req_rdy, c1_resp_msg, c1_resp_val, c1_resp_rdy: same for requester 1
- dma_req_msg  out  mem_req_64B_t  request to DMA
- dma_req_val / dma_req_rdy  out / in  1  DMA request handshake
- dma_resp_msg  in  mem_resp_64B_t  DMA response
- dma_resp_val / dma_resp_rdy  in / out  1  DMA response handshake
- busy  out  1  high in SEND or WAIT
- grant_id  out  1  requester owning the current transaction (valid when busy)

## Operation
- States: IDLE, SEND, WAIT.
- IDLE: round-robin pick among asserted c*_req_val; priority pointer prio (1 bit) names the favoured requester. Winner = prio if its val is high, else the other if its val is high. Winner's req_rdy = 1 combinationally; loser's req_rdy = 0. On handshake: latch full request message into req_reg, latch grant_id, go to SEND. No val: stay in IDLE, both rdy 0.
- SEND: dma_req_val = 1, dma_req_msg = req_reg (all fields unmodified, opaque passed through). On dma_req_rdy: go to WAIT. Both c*_req_rdy = 0.
- WAIT: dma_resp_msg forwarded combinationally to c{grant_id}_resp_msg; c{grant_id}_resp_val = dma_resp_val; dma_resp_rdy = c{grant_id}_resp_rdy. Other requester's resp_val = 0, resp_msg = 0.
- Completion in WAIT: dma_resp_val && (c{grant_id}_resp_rdy || dma_resp_msg.type_ == WRITE). Write responses complete even without cache rdy, because the DMA drops a presented write response after one cycle. On completion: go to IDLE, prio <= ~grant_id.
- Stray dma_resp_val in IDLE or SEND: ignored, dma_resp_rdy = 0.
- Request messages are never altered; response data (512 bits), type_, opaque forwarded unchanged.

## Timing
- Reset (async, immediate): state IDLE, prio = 0, grant_id = 0, req_reg = 0. All val/rdy outputs 0 while reset high; busy = 0.
- Request acceptance to dma_req_val: 1 cycle (accept at edge N, dma_req_val high in cycle N+1).
- dma_req_val held high and dma_req_msg stable until dma_req_rdy.
- Response path: zero-cycle combinational pass-through; completion edge returns to IDLE, new request acceptable in following cycle (minimum 1 idle cycle between transactions).
- Simultaneous c0/c1 val in IDLE: prio decides; after completion prio flips away from finished requester, so two persistently requesting caches alternate strictly.
- Requester dropping val before handshake: no effect (nothing latched).
- Reset mid-SEND or mid-WAIT: transaction abandoned, no response delivered; outputs drop to 0 asynchronously.
- One outstanding transaction only; DMA never sees a second request before the first completes.

## Structure
- Package lab3_cache_dma_arb_pkg: state_t enum (IDLE, SEND, WAIT), MEM_TYPE_READ = 3'd0, MEM_TYPE_WRITE = 3'd1.
- Sub-module lab3_cache_rr_arb2: combinational 2-way round-robin pick from (val[1:0], prio) giving grant one-hot; prio register lives in the top-level FSM.
- Message structs reused from existing wide and standard mem-msg headers.

## Test plan
- Single read from c0, addr 0x1000: c0_req_rdy same cycle, dma_req_val next cycle with addr 0x1000, opaque preserved; DMA read response data 0xA5.. routed only to c0, c1_resp_val stays 0.
- c0 and c1 request same cycle after reset: c0 granted first (prio 0); after c0 completes, c1 granted; a further simultaneous pair grants c0 again (strict alternation).
- Write from c1 with c1_resp_rdy = 0: DMA presents write response (type_ 1) one cycle; arbiter returns to IDLE, busy = 0 next cycle.
- Read with c0_resp_rdy low 5 cycles: dma_resp_rdy low those cycles, state stays WAIT; completion on first cycle c0_resp_rdy = 1.
- dma_req_rdy held low 4 cycles in SEND: dma_req_msg stable, both c*_req_rdy = 0; new c1 val waits until completion.
- Reset asserted mid-WAIT: busy, dma_req_val, dma_resp_rdy, all resp_val drop to 0 without clock edge; after release, first c1 request granted normally.
